pipe_reg_chain: RTL and testbench
=================================

Name: pipe_reg_chain

Overview:
- Parametrised pipeline register chain; next generation of the single-stage MEM/WB register.
- Carries an opaque payload plus valid bit through STAGES register stages.
- Supports start gating, stall hold, flush-to-bubble and zeroed bubble payloads.
- Reports occupancy and a saturating stall-cycle count for performance and hazard logic.
- Instantiated between EX/MEM, MEM/WB and any added retiming stages.

Parameters:
- DATA_W, 71, payload width (default = RegWrite 1 + Memdata 32 + ALUResult 32 + MemtoReg 1 + RDaddr 5).
- STAGES, 1, number of register stages; legal range 1..8.
- ZERO_BUBBLE, 1, 1 = payload of invalid stages forced to 0; 0 = payload of invalid stages left unchanged.
- CNT_W, 16, stall counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  core run enable; low loads bubbles.
- stall_i  in  1  hold all stages.
- flush_i  in  1  invalidate all stages.
- valid_i  in  1  input payload valid.
- data_i  in  DATA_W  input payload.
- valid_o  in/out: out  1  valid of the last stage.
- data_o  out  DATA_W  payload of the last stage.
- stage_valid_o  out  STAGES  per-stage valid; bit 0 = first stage.
- occupancy_o  out  $clog2(STAGES+1)  count of valid stages.
- stall_cnt_o  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset: rst_i high asynchronously clears all stage valids, all stage payloads, valid_o, data_o, occupancy_o and stall_cnt_o to 0.
- Latency: exactly STAGES cycles from data_i to data_o when there is no stall.
- Priority at each clock edge, highest first: flush_i, then stall_i, then !start_i, then advance.
- Flush (flush_i=1):
  - All stage valids become 0.
  - Payloads become 0 if ZERO_BUBBLE=1.
  - Flush wins over a simultaneous stall; the input on that cycle is dropped.
- Stall (stall_i=1, flush_i=0):
  - Every stage holds valid and payload.
  - The input on that cycle is not captured; the upstream stage must hold it.
- Not started (start_i=0, no flush or stall):
  - Stage 0 loads a bubble (valid 0, payload 0).
  - Stages 1..STAGES-1 shift normally, so the pipe drains.
- Advance:
  - Stage 0 captures valid_i and data_i. If valid_i=0 and ZERO_BUBBLE=1, stage 0's payload is 0.
  - Stage k (k≥1) captures stage k-1.
- ZERO_BUBBLE=1 guarantees that any stage with valid=0 holds payload 0, so downstream RegWrite reads 0. The bench checks this invariant every cycle.
- Outputs:
  - valid_o and data_o are the last stage's registers directly; no combinational path from the inputs.
  - occupancy_o is the registered popcount of the stage valids after the same edge update; range 0..STAGES.
- stall_cnt_o:
  - Increments by 1 on each edge where stall_i=1, flush_i=0 and start_i=1.
  - Saturates at 2^CNT_W−1 and never wraps.
  - Cleared only by reset.
- STAGES=1 reproduces the legacy single-register behaviour, except for two intentional changes: flush priority and active-high reset.
- Asserting reset mid-stream discards all in-flight data immediately; the first valid output after reset release appears STAGES cycles after the first accepted valid_i.
- Out-of-range STAGES or DATA_W<1 is rejected at elaboration by a generate-time error.

Decomposition:
- Package pipe_pkg:
  - Field-width constants: REG_ADDR_W=5, XLEN=32, MEMWB_W=71.
  - A packed struct memwb_payload_t (regwrite, memdata, aluresult, memtoreg, rdaddr) so instances cast cleanly.
- Sub-module pipe_stage: one valid+payload register with the flush/stall/load/bubble inputs and the ZERO_BUBBLE parameter.
- pipe_reg_chain generates STAGES instances of pipe_stage, plus the occupancy popcount and stall counter.

Test Plan:
- Reset mid-stream: STAGES=3, stream valid payloads 0x1..0x5, assert rst_i during the cycle payload 0x3 enters → on the same edge, valid_o=0, data_o=0, occupancy_o=0, stall_cnt_o=0; after release, feeding 0xA5 produces valid_o=1, data_o=0xA5 exactly 3 cycles later.
- Latency and order: STAGES=3, start_i=1, back-to-back valid payloads 0x11, 0x22, 0x33 → data_o shows 0x11, 0x22, 0x33 on cycles 3, 4, 5; occupancy_o reaches 3.
- Stall hold: a 2-cycle stall with the pipe full → all outputs frozen for 2 cycles; stall_cnt_o goes 0→2; the input presented during the stall is not captured.
- Flush wins: flush_i=1 and stall_i=1 on the same edge with occupancy 3 → next cycle occupancy_o=0, all stage_valid_o=0, data_o=0 (ZERO_BUBBLE=1), stall_cnt_o unchanged.
- start_i low drain: STAGES=2 full, drop start_i → valid_o stays 1 for one more cycle, then goes 0; occupancy_o goes 2→1→0.
- Saturation: CNT_W=4, hold stall_i=1 for 20 cycles → stall_cnt_o reaches 15 and stays at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline register chain.
//  - Field-width constants for the MEM/WB payload.
//  - memwb_payload_t: packed MEM/WB payload so instances can cast
//    between the struct and a flat DATA_W-bit vector.
//  - count_ones(): popcount over a stage-valid vector of up to MAX_STAGES bits.
package pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int MEMWB_W    = 71;
  localparam int MAX_STAGES = 8;

  // Field order matches the legacy MEM/WB bit layout, MSB first.
  typedef struct packed {
    logic                  regwrite;
    logic [XLEN-1:0]       memdata;
    logic [XLEN-1:0]       aluresult;
    logic                  memtoreg;
    logic [REG_ADDR_W-1:0] rdaddr;
  } memwb_payload_t;

  // Four bits is enough to count up to MAX_STAGES valid stages.
  function automatic logic [3:0] count_ones(input logic [MAX_STAGES-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < MAX_STAGES; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid + payload register of the pipeline chain.
// Ports:
//   clk_i, rst_i   clock (rising edge), asynchronous active-high reset
//   flush_i        invalidate this stage (payload zeroed when ZERO_BUBBLE)
//   hold_i         keep current valid and payload
//   bubble_i       load an empty slot (valid 0, payload 0)
//   valid_i        incoming valid
//   data_i         incoming payload
//   valid_next_o   value valid_o takes at the next edge
//   valid_o        registered valid
//   data_o         registered payload
// Control priority: flush_i, then hold_i, then bubble_i, then load.
module pipe_stage #(
  parameter int DATA_W      = 71,
  parameter bit ZERO_BUBBLE = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              hold_i,
  input  logic              bubble_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_next_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_reg;
  logic              valid_next;
  logic [DATA_W-1:0] data_reg;
  logic [DATA_W-1:0] data_next;

  always_comb begin
    valid_next = valid_reg;
    data_next  = data_reg;
    if (flush_i) begin
      valid_next = 1'b0;
      if (ZERO_BUBBLE) begin
        data_next = '0;
      end
    end else if (!hold_i) begin
      if (bubble_i) begin
        valid_next = 1'b0;
        data_next  = '0;
      end else begin
        valid_next = valid_i;
        // An invalid slot never carries a stale payload when bubbles are zeroed.
        data_next  = (ZERO_BUBBLE && !valid_i) ? '0 : data_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else begin
      valid_reg <= valid_next;
      data_reg  <= data_next;
    end
  end

  assign valid_next_o = valid_next;
  assign valid_o      = valid_reg;
  assign data_o       = data_reg;

endmodule

// File: rtl/pipe_reg_chain.sv
// Parametrised pipeline register chain (generalised MEM/WB register).
// Carries a payload plus valid bit through STAGES registers with flush,
// stall, start gating and optional zeroing of bubble payloads.
// Ports:
//   clk_i, rst_i    clock (rising edge), asynchronous active-high reset
//   start_i         run enable; low feeds bubbles into stage 0
//   stall_i         hold every stage
//   flush_i         invalidate every stage (beats stall)
//   valid_i, data_i input slot
//   valid_o, data_o last stage registers
//   stage_valid_o   per-stage valid, bit 0 = first stage
//   occupancy_o     registered count of valid stages
//   stall_cnt_o     saturating count of stalled cycles
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int DATA_W      = MEMWB_W,
  parameter int STAGES      = 1,
  parameter bit ZERO_BUBBLE = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         stall_i,
  input  logic                         flush_i,
  input  logic                         valid_i,
  input  logic [DATA_W-1:0]            data_i,
  output logic                         valid_o,
  output logic [DATA_W-1:0]            data_o,
  output logic [STAGES-1:0]            stage_valid_o,
  output logic [$clog2(STAGES+1)-1:0]  occupancy_o,
  output logic [CNT_W-1:0]             stall_cnt_o
);

  localparam int OCC_W = $clog2(STAGES + 1);

  if (STAGES < 1 || STAGES > MAX_STAGES || DATA_W < 1) begin : g_param_err
    $error("pipe_reg_chain: STAGES must be 1..8 and DATA_W must be >= 1");
  end

  if ($bits(memwb_payload_t) != MEMWB_W) begin : g_pkg_err
    $error("pipe_reg_chain: memwb_payload_t width differs from MEMWB_W");
  end

  logic [STAGES-1:0] valid_vec;
  logic [STAGES-1:0] valid_next_vec;
  logic [DATA_W-1:0] data_arr [STAGES];

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    logic              stage_valid_in;
    logic [DATA_W-1:0] stage_data_in;
    logic              stage_bubble;

    if (gi == 0) begin : g_first
      assign stage_valid_in = valid_i;
      assign stage_data_in  = data_i;
      // Only the head of the chain is starved when the core is not running;
      // later stages keep shifting so the pipe drains.
      assign stage_bubble   = !start_i;
    end else begin : g_rest
      assign stage_valid_in = valid_vec[gi-1];
      assign stage_data_in  = data_arr[gi-1];
      assign stage_bubble   = 1'b0;
    end

    pipe_stage #(
      .DATA_W      (DATA_W),
      .ZERO_BUBBLE (ZERO_BUBBLE)
    ) u_stage (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .flush_i      (flush_i),
      .hold_i       (stall_i),
      .bubble_i     (stage_bubble),
      .valid_i      (stage_valid_in),
      .data_i       (stage_data_in),
      .valid_next_o (valid_next_vec[gi]),
      .valid_o      (valid_vec[gi]),
      .data_o       (data_arr[gi])
    );
  end

  // Occupancy is counted from the next-state valids so the register
  // tracks the stage valids on the same edge instead of lagging by one.
  logic [OCC_W-1:0] occupancy_reg;
  logic [OCC_W-1:0] occupancy_next;

  assign occupancy_next = OCC_W'(count_ones(MAX_STAGES'(valid_next_vec)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occupancy_reg <= '0;
    end else begin
      occupancy_reg <= occupancy_next;
    end
  end

  // A stall cycle only counts when it actually holds a running pipe:
  // a flush overrides it and a stopped core is not a hazard stall.
  logic             stall_event;
  logic [CNT_W-1:0] stall_cnt_reg;

  assign stall_event = stall_i && !flush_i && start_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_reg <= '0;
    end else if (stall_event && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign valid_o       = valid_vec[STAGES-1];
  assign data_o        = data_arr[STAGES-1];
  assign stage_valid_o = valid_vec;
  assign occupancy_o   = occupancy_reg;
  assign stall_cnt_o   = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: three configurations driven from the same inputs.
//   A: STAGES=3, DATA_W=71, ZERO_BUBBLE=1, CNT_W=16
//   B: STAGES=2, DATA_W=16, ZERO_BUBBLE=1, CNT_W=4
//   C: STAGES=1, DATA_W=16, ZERO_BUBBLE=0, CNT_W=4
// Each is compared every cycle with an array model of the chain, plus
// directed checks with fixed expected values.
module tb_pipe_reg_chain;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stall;
  logic        flush;
  logic        vin;
  logic [70:0] din;

  logic        a_vo;
  logic [70:0] a_do;
  logic [2:0]  a_sv;
  logic [1:0]  a_occ;
  logic [15:0] a_cnt;

  logic        b_vo;
  logic [15:0] b_do;
  logic [1:0]  b_sv;
  logic [1:0]  b_occ;
  logic [3:0]  b_cnt;

  logic        c_vo;
  logic [15:0] c_do;
  logic [0:0]  c_sv;
  logic [0:0]  c_occ;
  logic [3:0]  c_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  pipe_reg_chain #(.DATA_W(71), .STAGES(3), .ZERO_BUBBLE(1'b1), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
    .valid_i(vin), .data_i(din), .valid_o(a_vo), .data_o(a_do),
    .stage_valid_o(a_sv), .occupancy_o(a_occ), .stall_cnt_o(a_cnt));

  pipe_reg_chain #(.DATA_W(16), .STAGES(2), .ZERO_BUBBLE(1'b1), .CNT_W(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
    .valid_i(vin), .data_i(din[15:0]), .valid_o(b_vo), .data_o(b_do),
    .stage_valid_o(b_sv), .occupancy_o(b_occ), .stall_cnt_o(b_cnt));

  pipe_reg_chain #(.DATA_W(16), .STAGES(1), .ZERO_BUBBLE(1'b0), .CNT_W(4)) dut_c (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
    .valid_i(vin), .data_i(din[15:0]), .valid_o(c_vo), .data_o(c_do),
    .stage_valid_o(c_sv), .occupancy_o(c_occ), .stall_cnt_o(c_cnt));

  // Reference model: slot arrays per configuration.
  int          ns   [3] = '{3, 2, 1};
  bit          zb   [3] = '{1'b1, 1'b1, 1'b0};
  int          cmax [3] = '{65535, 15, 15};
  logic        mv   [3][8];
  logic [70:0] md   [3][8];
  int          mcnt [3];

  function automatic logic [70:0] trunc(input int d, input logic [70:0] x);
    return (d == 0) ? x : {55'b0, x[15:0]};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 8; k++) begin
        mv[d][k] = 1'b0;
        md[d][k] = '0;
      end
      mcnt[d] = 0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      if (flush) begin
        for (int k = 0; k < ns[d]; k++) begin
          mv[d][k] = 1'b0;
          if (zb[d]) md[d][k] = '0;
        end
      end else if (stall) begin
        if (start && mcnt[d] < cmax[d]) mcnt[d]++;
      end else begin
        for (int k = ns[d] - 1; k >= 1; k--) begin
          mv[d][k] = mv[d][k-1];
          md[d][k] = md[d][k-1];
        end
        if (start) begin
          mv[d][0] = vin;
          md[d][0] = (zb[d] && !vin) ? 71'b0 : trunc(d, din);
        end else begin
          mv[d][0] = 1'b0;
          md[d][0] = '0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input int d, input logic [70:0] obs, input logic [70:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h", tag, d, cyc, obs, exp);
    end
  endtask

  task automatic check_dut(input int d, input logic vo, input logic [70:0] dout,
                           input logic [7:0] sv, input int occ, input int cnt);
    logic [7:0] exp_sv;
    int         exp_occ;
    exp_sv  = '0;
    exp_occ = 0;
    for (int k = 0; k < ns[d]; k++) begin
      exp_sv[k] = mv[d][k];
      if (mv[d][k]) exp_occ++;
    end
    chk("valid_o", d, {70'b0, vo}, {70'b0, mv[d][ns[d]-1]});
    chk("data_o", d, dout, md[d][ns[d]-1]);
    chk("stage_valid_o", d, {63'b0, sv}, {63'b0, exp_sv});
    chk("occupancy_o", d, 71'(occ), 71'(exp_occ));
    chk("stall_cnt_o", d, 71'(cnt), 71'(mcnt[d]));
    if (zb[d] && !vo) chk("zero_bubble", d, dout, 71'b0);
  endtask

  task automatic check_all();
    check_dut(0, a_vo, a_do, {5'b0, a_sv}, int'(a_occ), int'(a_cnt));
    check_dut(1, b_vo, {55'b0, b_do}, {6'b0, b_sv}, int'(b_occ), int'(b_cnt));
    check_dut(2, c_vo, {55'b0, c_do}, {7'b0, c_sv}, int'(c_occ), int'(c_cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    cyc++;
    #1;
    check_all();
    $display("cyc=%0d rst=%b start=%b stall=%b flush=%b vin=%b din=%0h | A v=%b d=%0h occ=%0d cnt=%0d | B v=%b d=%0h occ=%0d cnt=%0d | C v=%b d=%0h cnt=%0d",
             cyc, rst, start, stall, flush, vin, din, a_vo, a_do, a_occ, a_cnt,
             b_vo, b_do, b_occ, b_cnt, c_vo, c_do, c_cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; flush = 1'b0; vin = 1'b0; din = '0;
    #1;
    model_reset();
    check_all();
    tick();
    tick();
    rst = 1'b0;

    // Latency and order: 0x11,0x22,0x33 appear on edges 3,4,5.
    start = 1'b1; vin = 1'b1;
    din = 71'h11; tick();
    din = 71'h22; tick();
    din = 71'h33; tick();
    chk("lat_edge3", 0, a_do, 71'h11);
    chk("occ_full", 0, 71'(a_occ), 71'd3);
    din = 71'h44; tick();
    chk("lat_edge4", 0, a_do, 71'h22);
    din = 71'h55; tick();
    chk("lat_edge5", 0, a_do, 71'h33);

    // Stall hold with a full pipe; 0x66 offered during the stall is dropped.
    stall = 1'b1; din = 71'h66;
    tick();
    chk("stall_hold1", 0, a_do, 71'h33);
    tick();
    chk("stall_hold2", 0, a_do, 71'h33);
    chk("stall_cnt2", 0, 71'(a_cnt), 71'd2);
    stall = 1'b0; vin = 1'b0;
    tick();
    chk("after_stall1", 0, a_do, 71'h44);
    tick();
    chk("after_stall2", 0, a_do, 71'h55);
    tick();
    chk("stall_drop", 0, {70'b0, a_vo}, 71'd0);

    // Flush beats a simultaneous stall.
    vin = 1'b1;
    din = 71'h77; tick();
    din = 71'h88; tick();
    din = 71'h99; tick();
    flush = 1'b1; stall = 1'b1; din = 71'hAA;
    tick();
    chk("flush_occ", 0, 71'(a_occ), 71'd0);
    chk("flush_sv", 0, 71'(a_sv), 71'd0);
    chk("flush_data", 0, a_do, 71'd0);
    chk("flush_cnt", 0, 71'(a_cnt), 71'd2);
    flush = 1'b0; stall = 1'b0;

    // start_i low drains the 2-stage chain.
    din = 71'h1234; tick();
    din = 71'h5678; tick();
    chk("drain_full", 1, 71'(b_occ), 71'd2);
    start = 1'b0;
    tick();
    chk("drain_v1", 1, {70'b0, b_vo}, 71'd1);
    chk("drain_occ1", 1, 71'(b_occ), 71'd1);
    tick();
    chk("drain_v0", 1, {70'b0, b_vo}, 71'd0);
    chk("drain_occ0", 1, 71'(b_occ), 71'd0);

    // Stall counter saturation on the 4-bit counter.
    start = 1'b1; stall = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_cnt", 1, 71'(b_cnt), 71'd15);
    stall = 1'b0;

    // Reset mid-stream, asserted while 0x3 is being presented.
    vin = 1'b1;
    din = 71'h1; tick();
    din = 71'h2; tick();
    din = 71'h3;
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_valid", 0, {70'b0, a_vo}, 71'd0);
    chk("rst_data", 0, a_do, 71'd0);
    chk("rst_occ", 0, 71'(a_occ), 71'd0);
    chk("rst_cnt", 0, 71'(a_cnt), 71'd0);
    check_all();
    tick();
    rst = 1'b0;
    din = 71'hA5; tick();
    vin = 1'b0;
    tick();
    chk("rst_lat2", 0, {70'b0, a_vo}, 71'd0);
    tick();
    chk("rst_lat3_v", 0, {70'b0, a_vo}, 71'd1);
    chk("rst_lat3_d", 0, a_do, 71'hA5);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      start = ($urandom % 8) != 0;
      stall = ($urandom % 5) == 0;
      flush = ($urandom % 16) == 0;
      vin   = $urandom % 2;
      din   = 71'({$urandom, $urandom, $urandom});
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
